cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
//  16-bit load/store CPU core with separate instruction and data buses (Harvard).
//  Sixteen 16-bit registers, single-word instructions, register-indirect memory and jumps.
//  Sits between an instruction ROM (IA/ID) and a data RAM on a bidirectional DD bus;
//  both memories update their outputs on the falling edge of CK.
// PARAMETERS
//  none (data/address width fixed at 16, register file fixed at 16 entries)
// PORTS
//  CK   in    1   clock; all state changes on rising edge
//  RST  in    1   reset, asynchronous, active-high
//  IA   out   16  instruction address (= PC)
//  ID   in    16  instruction word, valid from the falling edge after IA changes
//  DA   out   16  data address
//  DD   inout 16  data bus; CPU drives it only while RW=0, else high-Z
//  RW   out   1   1 = read (default), 0 = write
// BEHAVIOUR
//  Reset (async, RST=1): PC=0 (IA=0), DA=0, RW=1, DD released, all registers R0..R15=0,
//   Z=0, state=EXEC. Reset mid-LD/ST aborts the access immediately.
//  Encoding: op=ID[15:12], d=ID[11:8], a=ID[7:4], b=ID[3:0], imm=ID[7:0].
//  0000 ADD R[d]=R[a]+R[b]      0001 SUB R[d]=R[a]-R[b]  (mod 2^16, no carry)
//  0010 SHR R[d]=R[a]>>R[b][3:0] (logical)   0011 SHL R[d]=R[a]<<R[b][3:0]
//  0100 OR  0101 AND  0110 XOR R[d]=R[a] op R[b]   0111 NOT R[d]=~R[a]
//  1000 JMP PC=R[b]             1001 BZ  if Z: PC=R[b] else PC+1
//  1010 ST  MEM[R[b]]=R[a]      1011 LD  R[d]=MEM[R[b]]
//  1100 LDI R[d]={8'h00,imm}    1101..1111 NOP
//  Z flag: updated only by ops 0000-0111 (Z = result==0); held otherwise.
//  R0 is an ordinary register (not hardwired zero).
//  States: EXEC, MEM.
//  EXEC (rising edge, ID valid): ALU/LDI/NOP -> write R[d], PC=PC+1, stay EXEC (1 cycle).
//   JMP/BZ -> PC updated, stay EXEC (1 cycle).
//   LD -> DA<=R[b], RW<=1, latch d, PC held, go MEM.
//   ST -> DA<=R[b], DD out<=R[a], RW<=0, PC held, go MEM.
//  MEM (next rising edge): LD -> R[d]<=DD (read data returned on intervening falling edge);
//   ST -> RW<=1 (bus released; RAM wrote on intervening falling edge). PC=PC+1, go EXEC.
//  LD/ST take 2 cycles. DA, RW, DD-out are registered; DA holds its last value after access.
//  PC wraps 0xFFFF->0x0000. Register write with d=b in LD uses the pre-load address.
//  Operand reads are combinational from the register file; writes on rising edge.
// STRUCTURE
//  Package cpu_pkg: opcode localparams (OP_ADD..OP_LDI), state enum {EXEC,MEM}, widths.
//  Sub-module cpu_alu: combinational op[2:0], a, b -> y[15:0], zero.
//  Top holds PC, register file, Z, FSM and bus registers.
// TESTING
//  1 Reset: RST=1 -> IA=0, DA=0, RW=1, DD=Z; release -> first instruction fetched from IA=0.
//  2 LDI R1,0x0F; LDI R2,3; ADD R3,R1,R2; LDI R9,0; ST [R9],R3 -> write cycle DA=0, DD=0x0012, RW=0.
//  3 LDI R5,1; LDI R4,15; SHL R5,R5,R4 -> R5=0x8000; LDI R4,1; SHR R5,R5,R4 -> 0x4000; ST shows 0x4000.
//  4 DMEM[1]=50; LDI R10,1; LD R3,[R10] -> RW=1, DA=1 one cycle, R3=50; ST confirms 50.
//  5 AND result 0 then BZ R7 (R7=20) -> IA=20; AND result nonzero -> IA=PC+1; JMP R8 (R8=13) -> IA=13.
//  6 Shift-add multiply loop, DMEM[0]=5, DMEM[1]=50 -> final ST writes DA=2, DD=250; assert RST
//    during an ST's MEM cycle -> RW=1 and DA=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit Harvard load/store CPU.
// Opcodes, FSM state constants and the instruction field layout.
package cpu_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned NREG = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SHR = 4'h2;
  localparam logic [3:0] OP_SHL = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BZ  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_LD  = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;

  localparam logic [0:0] EXEC = 1'b0;
  localparam logic [0:0] MEM  = 1'b1;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] d;
    logic [3:0] a;
    logic [3:0] b;
  } instr_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes 0000-0111; zero flags an all-zero result.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  always_comb begin
    y = '0;
    case (op)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a >> b[3:0];
      3'd3: y = a << b[3:0];
      3'd4: y = a | b;
      3'd5: y = a & b;
      3'd6: y = a ^ b;
      3'd7: y = ~a;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/cpu.sv
// 16-bit load/store CPU core: PC, register file, Z flag, EXEC/MEM FSM and
// registered data-bus outputs (DA, RW, DD drive).
module cpu
  import cpu_pkg::*;
(
  input  logic            CK,
  input  logic            RST,
  output logic [XLEN-1:0] IA,
  input  logic [XLEN-1:0] ID,
  output logic [XLEN-1:0] DA,
  inout  wire  [XLEN-1:0] DD,
  output logic            RW
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic            z_q, z_d;
  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] da_q, da_d;
  logic [XLEN-1:0] dout_q, dout_d;
  logic            rw_q, rw_d;
  logic [3:0]      ldrd_q, ldrd_d;
  logic            isld_q, isld_d;

  logic            wen;
  logic [3:0]      waddr;
  logic [XLEN-1:0] wdata;

  instr_t          ins;
  logic [XLEN-1:0] ra, rb, alu_y;
  logic            alu_zero;

  assign ins = ID;
  assign ra  = regs_q[ins.a];
  assign rb  = regs_q[ins.b];

  cpu_alu u_alu (
    .op   (ins.op[2:0]),
    .a    (ra),
    .b    (rb),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    pc_d    = pc_q;
    z_d     = z_q;
    state_d = state_q;
    da_d    = da_q;
    dout_d  = dout_q;
    rw_d    = rw_q;
    ldrd_d  = ldrd_q;
    isld_d  = isld_q;
    wen     = 1'b0;
    waddr   = ins.d;
    wdata   = alu_y;
    if (state_q == EXEC) begin
      case (ins.op)
        OP_JMP: pc_d = rb;
        OP_BZ:  pc_d = z_q ? rb : pc_q + 16'd1;
        OP_ST: begin
          da_d    = rb;
          dout_d  = ra;
          rw_d    = 1'b0;
          isld_d  = 1'b0;
          state_d = MEM;
        end
        OP_LD: begin
          da_d    = rb;
          rw_d    = 1'b1;
          ldrd_d  = ins.d;
          isld_d  = 1'b1;
          state_d = MEM;
        end
        OP_LDI: begin
          wen   = 1'b1;
          wdata = {8'h00, ins.a, ins.b};
          pc_d  = pc_q + 16'd1;
        end
        default: begin
          // ALU ops write back and set Z; 1101-1111 are plain NOPs
          if (!ins.op[3]) begin
            wen = 1'b1;
            z_d = alu_zero;
          end
          pc_d = pc_q + 16'd1;
        end
      endcase
    end else begin
      if (isld_q) begin
        wen   = 1'b1;
        waddr = ldrd_q;
        wdata = DD;
      end
      rw_d    = 1'b1;
      pc_d    = pc_q + 16'd1;
      state_d = EXEC;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      pc_q    <= '0;
      z_q     <= 1'b0;
      state_q <= EXEC;
      da_q    <= '0;
      dout_q  <= '0;
      rw_q    <= 1'b1;
      ldrd_q  <= '0;
      isld_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      z_q     <= z_d;
      state_q <= state_d;
      da_q    <= da_d;
      dout_q  <= dout_d;
      rw_q    <= rw_d;
      ldrd_q  <= ldrd_d;
      isld_q  <= isld_d;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wen) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign IA = pc_q;
  assign DA = da_q;
  assign RW = rw_q;
  assign DD = rw_q ? {XLEN{1'bz}} : dout_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: ROM/RAM models on the falling edge and an
// instruction-level reference model predicting the bus every cycle.
module tb_cpu;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] IA, ID, DA;
  wire  [15:0] DD;
  logic        RW;
  logic [15:0] ram_out;

  logic [15:0] imem [256];
  logic [15:0] dmem [65536];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] m_r [16];
  logic [15:0] m_pc, m_da, m_dd, m_w;
  logic        m_z, m_rw, m_pend;
  logic [15:0] m_dm [65536];

  logic [15:0] st_da [$];
  logic [15:0] st_dd [$];
  logic [15:0] ia_hist [1024];
  logic [15:0] da_hist [1024];
  logic        rw_hist [1024];

  assign DD = RW ? ram_out : 16'hzzzz;

  cpu dut (
    .CK (CK),
    .RST(RST),
    .IA (IA),
    .ID (ID),
    .DA (DA),
    .DD (DD),
    .RW (RW)
  );

  always #5 CK = ~CK;

  always @(negedge CK) begin
    ID <= imem[IA[7:0]];
    if (!RW && !RST) dmem[DA] = DD;
    ram_out <= dmem[DA];
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
    return {op, d, a, b};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] d, input logic [7:0] imm);
    return {4'hC, d, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic init_mem();
    logic [15:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      dmem[i] = v;
      m_dm[i] = v;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_pc = 0; m_da = 0; m_dd = 0; m_w = 0;
    m_z = 0; m_rw = 1; m_pend = 0;
    st_da.delete();
    st_dd.delete();
  endtask

  // One clock of the ISA: an instruction takes one cycle, LD/ST take two.
  task automatic model_cycle();
    logic [15:0] w, ra, rb, res;
    logic [3:0]  op;
    if (m_pend) begin
      if (m_w[15:12] == 4'hB) m_r[m_w[11:8]] = m_dm[m_da];
      else m_dm[m_da] = m_dd;
      m_rw = 1; m_pc = m_pc + 16'd1; m_pend = 0;
    end else begin
      w  = imem[m_pc[7:0]];
      op = w[15:12];
      ra = m_r[w[7:4]];
      rb = m_r[w[3:0]];
      res = 16'h0;
      case (op)
        4'h0: res = ra + rb;
        4'h1: res = ra - rb;
        4'h2: res = ra >> rb[3:0];
        4'h3: res = ra << rb[3:0];
        4'h4: res = ra | rb;
        4'h5: res = ra & rb;
        4'h6: res = ra ^ rb;
        4'h7: res = ~ra;
        default: res = 16'h0;
      endcase
      if (op < 4'h8) begin
        m_r[w[11:8]] = res; m_z = (res == 16'h0); m_pc = m_pc + 16'd1;
      end else if (op == 4'h8) m_pc = rb;
      else if (op == 4'h9) m_pc = m_z ? rb : m_pc + 16'd1;
      else if (op == 4'hA) begin
        m_da = rb; m_dd = ra; m_rw = 0; m_pend = 1; m_w = w;
      end else if (op == 4'hB) begin
        m_da = rb; m_rw = 1; m_pend = 1; m_w = w;
      end else if (op == 4'hC) begin
        m_r[w[11:8]] = {8'h00, w[7:0]}; m_pc = m_pc + 16'd1;
      end else m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CK);
    model_reset();
    RST = 1'b0;
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge CK);
      model_cycle();
      #1;
      ia_hist[c] = IA; da_hist[c] = DA; rw_hist[c] = RW;
      if (RW === 1'b0) begin
        st_da.push_back(DA);
        st_dd.push_back(DD);
      end
      n_cmp++;
      if (IA !== m_pc || DA !== m_da || RW !== m_rw || (!m_rw && DD !== m_dd)) begin
        n_bad++;
        $display("FAIL bus cyc%0d: IA=%h DA=%h RW=%b DD=%h, required IA=%h DA=%h RW=%b DD=%h",
                 c, IA, DA, RW, DD, m_pc, m_da, m_rw, m_dd);
        break;
      end
    end
  endtask

  task automatic check_store(input int k, input logic [15:0] da, input logic [15:0] dd);
    n_cmp++;
    if (st_da.size() <= k) begin
      n_bad++;
      $display("FAIL store%0d: only %0d writes seen, required DA=%h DD=%h",
               k, st_da.size(), da, dd);
    end else if (st_da[k] !== da || st_dd[k] !== dd) begin
      n_bad++;
      $display("FAIL store%0d: DA=%h DD=%h, required DA=%h DD=%h", k, st_da[k], st_dd[k], da, dd);
    end
  endtask

  task automatic test_reset();
    clear_imem();
    init_mem();
    imem[0] = ldi(4'd9, 8'h33);
    imem[1] = enc(4'hA, 4'd0, 4'd9, 4'd9);
    RST = 1'b1;
    repeat (2) @(negedge CK);
    n_cmp++;
    if (IA !== 16'h0 || DA !== 16'h0 || RW !== 1'b1 || DD !== ram_out) begin
      n_bad++;
      $display("FAIL reset_state: IA=%h DA=%h RW=%b, required 0000 0000 1", IA, DA, RW);
    end
    model_reset();
    RST = 1'b0;
    run(2);
    n_cmp++;
    if (ia_hist[0] !== 16'h1) begin
      n_bad++;
      $display("FAIL first_fetch: IA=%h, required 0001", ia_hist[0]);
    end
    // now in the MEM cycle of the ST: reset must abort it at once
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (RW !== 1'b1 || DA !== 16'h0 || IA !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_abort: IA=%h DA=%h RW=%b, required 0000 0000 1", IA, DA, RW);
    end
  endtask

  task automatic test_add_store();
    clear_imem();
    init_mem();
    imem[0] = ldi(4'd1, 8'h0F);
    imem[1] = ldi(4'd2, 8'h03);
    imem[2] = enc(4'h0, 4'd3, 4'd1, 4'd2);
    imem[3] = ldi(4'd9, 8'h00);
    imem[4] = enc(4'hA, 4'd0, 4'd3, 4'd9);
    do_reset();
    run(8);
    check_store(0, 16'h0000, 16'h0012);
  endtask

  task automatic test_shift();
    clear_imem();
    init_mem();
    imem[0] = ldi(4'd5, 8'd1);
    imem[1] = ldi(4'd4, 8'd15);
    imem[2] = enc(4'h3, 4'd5, 4'd5, 4'd4);
    imem[3] = enc(4'hA, 4'd0, 4'd5, 4'd9);
    imem[4] = ldi(4'd4, 8'd1);
    imem[5] = enc(4'h2, 4'd5, 4'd5, 4'd4);
    imem[6] = ldi(4'd9, 8'd1);
    imem[7] = enc(4'hA, 4'd0, 4'd5, 4'd9);
    do_reset();
    run(12);
    check_store(0, 16'h0000, 16'h8000);
    check_store(1, 16'h0001, 16'h4000);
  endtask

  task automatic test_load();
    clear_imem();
    init_mem();
    dmem[1] = 16'd50;
    m_dm[1] = 16'd50;
    imem[0] = ldi(4'd10, 8'd1);
    imem[1] = enc(4'hB, 4'd3, 4'd0, 4'd10);
    imem[2] = ldi(4'd11, 8'd7);
    imem[3] = enc(4'hA, 4'd0, 4'd3, 4'd11);
    do_reset();
    run(8);
    n_cmp++;
    if (da_hist[1] !== 16'h1 || rw_hist[1] !== 1'b1 || ia_hist[1] !== 16'h1 ||
        ia_hist[2] !== 16'h2) begin
      n_bad++;
      $display("FAIL ld_cycle: DA=%h RW=%b IA=%h,%h, required 0001 1 0001,0002",
               da_hist[1], rw_hist[1], ia_hist[1], ia_hist[2]);
    end
    check_store(0, 16'h0007, 16'd50);
  endtask

  task automatic test_branch();
    clear_imem();
    init_mem();
    imem[0]  = ldi(4'd7, 8'd20);
    imem[1]  = ldi(4'd1, 8'hF0);
    imem[2]  = ldi(4'd2, 8'h0F);
    imem[3]  = enc(4'h5, 4'd3, 4'd1, 4'd2);
    imem[4]  = enc(4'h9, 4'd0, 4'd0, 4'd7);
    imem[20] = enc(4'h5, 4'd3, 4'd1, 4'd1);
    imem[21] = enc(4'h9, 4'd0, 4'd0, 4'd7);
    imem[22] = ldi(4'd8, 8'd13);
    imem[23] = enc(4'h8, 4'd0, 4'd0, 4'd8);
    do_reset();
    run(10);
    n_cmp++;
    if (ia_hist[4] !== 16'd20 || ia_hist[6] !== 16'd22 || ia_hist[8] !== 16'd13) begin
      n_bad++;
      $display("FAIL branch: IA after BZ/BZ/JMP=%0d,%0d,%0d, required 20,22,13",
               ia_hist[4], ia_hist[6], ia_hist[8]);
    end
  endtask

  task automatic test_multiply();
    clear_imem();
    init_mem();
    dmem[0] = 16'd5;  m_dm[0] = 16'd5;
    dmem[1] = 16'd50; m_dm[1] = 16'd50;
    imem[0]  = ldi(4'd0, 8'd0);
    imem[1]  = enc(4'hB, 4'd1, 4'd0, 4'd0);
    imem[2]  = ldi(4'd0, 8'd1);
    imem[3]  = enc(4'hB, 4'd2, 4'd0, 4'd0);
    imem[4]  = ldi(4'd3, 8'd0);
    imem[5]  = ldi(4'd4, 8'd1);
    imem[6]  = ldi(4'd8, 8'd9);
    imem[7]  = ldi(4'd9, 8'd12);
    imem[8]  = ldi(4'd10, 8'd16);
    imem[9]  = enc(4'h5, 4'd5, 4'd1, 4'd4);
    imem[10] = enc(4'h9, 4'd0, 4'd0, 4'd9);
    imem[11] = enc(4'h0, 4'd3, 4'd3, 4'd2);
    imem[12] = enc(4'h3, 4'd2, 4'd2, 4'd4);
    imem[13] = enc(4'h2, 4'd1, 4'd1, 4'd4);
    imem[14] = enc(4'h9, 4'd0, 4'd0, 4'd10);
    imem[15] = enc(4'h8, 4'd0, 4'd0, 4'd8);
    imem[16] = ldi(4'd0, 8'd2);
    imem[17] = enc(4'hA, 4'd0, 4'd3, 4'd0);
    imem[18] = ldi(4'd11, 8'd19);
    imem[19] = enc(4'h8, 4'd0, 4'd0, 4'd11);
    do_reset();
    run(60);
    check_store(0, 16'h0002, 16'd250);
    n_cmp++;
    if (ia_hist[59] !== 16'd19) begin
      n_bad++;
      $display("FAIL mul_halt: IA=%0d, required 19", ia_hist[59]);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      clear_imem();
      init_mem();
      for (int i = 0; i < 64; i++) imem[i] = 16'($urandom);
      // seed some registers with small values so jumps and addresses vary
      for (int i = 0; i < 8; i++) imem[i] = ldi(4'(i * 2), 8'($urandom));
      do_reset();
      run(300);
    end
  endtask

  initial begin
    test_reset();
    test_add_store();
    test_shift();
    test_load();
    test_branch();
    test_multiply();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
